// File: rtl/oisc_alu_unit_if.sv
// rtl/oisc_alu_unit_if.sv - bus bundle between a one-instruction bus master and the ALU port unit
// Ports (signals): wr_en/wr_addr/data_in write side, rd_addr/data_out/rd_hit read side,
// carry flag, busy (multiplier running), stall (bus must hold the current transfer).
// Modports: master drives the bus, slave is the ALU unit.
interface oisc_alu_unit_if #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 5
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic [WIDTH-1:0]  data_in;
    logic [WIDTH-1:0]  data_out;
    logic              rd_hit;
    logic              carry;
    logic              busy;
    logic              stall;

    modport master (
        output wr_en, wr_addr, rd_addr, data_in,
        input  data_out, rd_hit, carry, busy, stall
    );

    modport slave (
        input  wr_en, wr_addr, rd_addr, data_in,
        output data_out, rd_hit, carry, busy, stall
    );
endinterface

// File: rtl/oisc_alu_unit.sv
// rtl/oisc_alu_unit.sv - memory-mapped ALU ports (ACC/ADD/SUB/AND/OR/XOR/CARRY/MUL/MULHI) for a move-only CPU
// Purpose: accumulator plus per-op operand registers whose reads return operand op acc;
// optional sequential shift-add multiplier, compiled only when OISC_ALU_MUL_EN is defined.
// Ports: clk - clock; rst - asynchronous active-low reset;
//        bus - oisc_alu_unit_if.slave (wr_en, wr_addr, rd_addr, data_in, data_out, rd_hit, carry, busy, stall).
// Port map: BASE+0 ACC, +1 ADD, +2 SUB, +3 AND, +4 OR, +5 XOR, +6 CARRY, +7 MUL, +8 MULHI.
module oisc_alu_unit #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 5,
    parameter int BASE   = 0
) (
    input  logic             clk,
    input  logic             rst,
    oisc_alu_unit_if.slave   bus
);
    localparam logic [ADDR_W-1:0] A_ACC   = ADDR_W'(BASE + 0);
    localparam logic [ADDR_W-1:0] A_ADD   = ADDR_W'(BASE + 1);
    localparam logic [ADDR_W-1:0] A_SUB   = ADDR_W'(BASE + 2);
    localparam logic [ADDR_W-1:0] A_AND   = ADDR_W'(BASE + 3);
    localparam logic [ADDR_W-1:0] A_OR    = ADDR_W'(BASE + 4);
    localparam logic [ADDR_W-1:0] A_XOR   = ADDR_W'(BASE + 5);
    localparam logic [ADDR_W-1:0] A_CARRY = ADDR_W'(BASE + 6);

    logic [WIDTH-1:0] acc_q, op_add_q, op_sub_q, op_and_q, op_or_q, op_xor_q;
    logic             carry_q, carry_d;
    logic [WIDTH:0]   add_full, sub_full;

    // Carry/borrow comes from the written value against the pre-edge accumulator.
    assign add_full = {1'b0, bus.data_in} + {1'b0, acc_q};
    assign sub_full = {1'b0, bus.data_in} - {1'b0, acc_q};

    always_comb begin
        carry_d = carry_q;
        if (bus.wr_en && bus.wr_addr == A_ADD)
            carry_d = add_full[WIDTH];
        else if (bus.wr_en && bus.wr_addr == A_SUB)
            carry_d = sub_full[WIDTH];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q    <= '0;
            op_add_q <= '0;
            op_sub_q <= '0;
            op_and_q <= '0;
            op_or_q  <= '0;
            op_xor_q <= '0;
            carry_q  <= 1'b0;
        end else begin
            carry_q <= carry_d;
            if (bus.wr_en) begin
                case (bus.wr_addr)
                    A_ACC:   acc_q    <= bus.data_in;
                    A_ADD:   op_add_q <= bus.data_in;
                    A_SUB:   op_sub_q <= bus.data_in;
                    A_AND:   op_and_q <= bus.data_in;
                    A_OR:    op_or_q  <= bus.data_in;
                    A_XOR:   op_xor_q <= bus.data_in;
                    default: ;
                endcase
            end
        end
    end

`ifdef OISC_ALU_MUL_EN
    localparam logic [ADDR_W-1:0] A_MUL   = ADDR_W'(BASE + 7);
    localparam logic [ADDR_W-1:0] A_MULHI = ADDR_W'(BASE + 8);
    localparam int                CNT_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t             state_q;
    logic               busy_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [2*WIDTH-1:0] mcand_q;    // snapshot of data_in, shifted left each step
    logic [WIDTH-1:0]   mplier_q;   // snapshot of acc, shifted right each step
    logic [2*WIDTH-1:0] part_q;     // running partial product
    logic [2*WIDTH-1:0] prod_q;     // last completed product, visible to reads
    logic [2*WIDTH-1:0] part_d;
    logic               mul_wr, mul_rd;

    assign mul_wr = bus.wr_en && bus.wr_addr == A_MUL;
    assign mul_rd = (bus.rd_addr == A_MUL) || (bus.rd_addr == A_MULHI);
    assign part_d = part_q + (mplier_q[0] ? mcand_q : '0);

    assign bus.busy  = busy_q;
    assign bus.stall = busy_q && (mul_rd || mul_wr);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            part_q   <= '0;
            prod_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (mul_wr) begin
                        mcand_q  <= {{WIDTH{1'b0}}, bus.data_in};
                        mplier_q <= acc_q;
                        part_q   <= '0;
                        cnt_q    <= '0;
                        state_q  <= S_BUSY;
                        busy_q   <= 1'b1;
                    end
                end
                S_BUSY: begin
                    part_q   <= part_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + 1'b1;
                    // The last step's sum goes straight to the result register.
                    if (cnt_q == CNT_LAST) begin
                        prod_q  <= part_d;
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end
`else
    assign bus.busy  = 1'b0;
    assign bus.stall = 1'b0;
`endif

    always_comb begin
        bus.data_out = '0;
        bus.rd_hit   = 1'b1;
        case (bus.rd_addr)
            A_ACC:   bus.data_out = acc_q;
            A_ADD:   bus.data_out = op_add_q + acc_q;
            A_SUB:   bus.data_out = op_sub_q - acc_q;
            A_AND:   bus.data_out = op_and_q & acc_q;
            A_OR:    bus.data_out = op_or_q | acc_q;
            A_XOR:   bus.data_out = op_xor_q ^ acc_q;
            A_CARRY: bus.data_out = WIDTH'(carry_q);
`ifdef OISC_ALU_MUL_EN
            A_MUL:   bus.data_out = prod_q[WIDTH-1:0];
            A_MULHI: bus.data_out = prod_q[2*WIDTH-1:WIDTH];
`endif
            default: bus.rd_hit = 1'b0;
        endcase
    end

    assign bus.carry = carry_q;
endmodule
